// File: rtl/mem_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : mem_arbiter
// Purpose  : Shares a single downstream memory port between the instruction
//            fetch unit (IFU) and the load/store unit (LSU). Exactly one
//            transaction is outstanding at a time. LSU has priority under
//            contention, but IFU is forced through after MAX_LSU_STREAK
//            consecutive contended LSU grants. A watchdog returns ERR_DATA
//            and sets a sticky err flag if the memory never responds.
// Revision : 1.0 - initial release
// ----------------------------------------------------------------------------
// Ports
//   clk             in   clock, rising edge
//   rst             in   asynchronous reset, active low
//   ifu_req_valid   in   IFU fetch request
//   ifu_req_ready   out  IFU request accepted this cycle (combinational)
//   ifu_addr        in   fetch address
//   ifu_resp_valid  out  one-cycle response pulse to IFU
//   ifu_rdata       out  fetched word, held between pulses
//   lsu_req_valid   in   LSU request
//   lsu_req_ready   out  LSU request accepted this cycle (combinational)
//   lsu_addr        in   data address
//   lsu_wen         in   1 = store, 0 = load
//   lsu_wdata       in   store data
//   lsu_wstrb       in   byte strobes
//   lsu_resp_valid  out  one-cycle response pulse to LSU (loads and stores)
//   lsu_rdata       out  load data, held between pulses
//   mem_req_valid   out  downstream request
//   mem_req_ready   in   downstream accepts request
//   mem_addr        out  latched address
//   mem_wdata       out  latched store data
//   mem_wen         out  latched write flag
//   mem_wstrb       out  latched strobes (zero for IFU requests)
//   mem_resp_valid  in   downstream response pulse
//   mem_rdata       in   downstream read data
//   err             out  sticky watchdog timeout flag
// ============================================================================
module mem_arbiter #(
  parameter int          TIMEOUT        = 255,
  parameter int          MAX_LSU_STREAK = 4,
  parameter logic [31:0] ERR_DATA       = 32'hDEAD_BEEF
) (
  input  logic        clk,
  input  logic        rst,

  input  logic        ifu_req_valid,
  output logic        ifu_req_ready,
  input  logic [31:0] ifu_addr,
  output logic        ifu_resp_valid,
  output logic [31:0] ifu_rdata,

  input  logic        lsu_req_valid,
  output logic        lsu_req_ready,
  input  logic [31:0] lsu_addr,
  input  logic        lsu_wen,
  input  logic [31:0] lsu_wdata,
  input  logic [3:0]  lsu_wstrb,
  output logic        lsu_resp_valid,
  output logic [31:0] lsu_rdata,

  output logic        mem_req_valid,
  input  logic        mem_req_ready,
  output logic [31:0] mem_addr,
  output logic [31:0] mem_wdata,
  output logic        mem_wen,
  output logic [3:0]  mem_wstrb,
  input  logic        mem_resp_valid,
  input  logic [31:0] mem_rdata,

  output logic        err
);

  localparam int CNT_W    = $clog2(TIMEOUT + 1);
  localparam int STREAK_W = $clog2(MAX_LSU_STREAK + 1);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    REQ  = 2'd1,
    WAIT = 2'd2,
    RESP = 2'd3
  } state_t;

  state_t              state_q, state_d;
  logic [STREAK_W-1:0] streak_q, streak_d;
  logic [CNT_W-1:0]    cnt_q, cnt_d;
  logic                owner_lsu_q, owner_lsu_d;   // 1 = LSU owns the transaction
  logic                mem_req_valid_q, mem_req_valid_d;
  logic [31:0]         mem_addr_q, mem_addr_d;
  logic [31:0]         mem_wdata_q, mem_wdata_d;
  logic                mem_wen_q, mem_wen_d;
  logic [3:0]          mem_wstrb_q, mem_wstrb_d;
  logic                ifu_resp_valid_q, ifu_resp_valid_d;
  logic                lsu_resp_valid_q, lsu_resp_valid_d;
  logic [31:0]         ifu_rdata_q, ifu_rdata_d;
  logic [31:0]         lsu_rdata_q, lsu_rdata_d;
  logic                err_q, err_d;

  logic                grant_lsu;
  logic                grant_ifu;
  logic                resp_fire;
  logic [31:0]         resp_data;

  always_comb begin
    // Arbitration: LSU wins contention until its streak is exhausted.
    grant_lsu = lsu_req_valid &&
                (!ifu_req_valid || (streak_q < STREAK_W'(MAX_LSU_STREAK)));
    grant_ifu = ifu_req_valid && !grant_lsu;

    // A real response in the final watchdog cycle takes precedence over the
    // timeout, so mem_resp_valid is checked first.
    resp_fire = mem_resp_valid || (cnt_q == CNT_W'(TIMEOUT - 1));
    resp_data = mem_resp_valid ? mem_rdata : ERR_DATA;

    state_d          = state_q;
    streak_d         = streak_q;
    cnt_d            = cnt_q;
    owner_lsu_d      = owner_lsu_q;
    mem_req_valid_d  = mem_req_valid_q;
    mem_addr_d       = mem_addr_q;
    mem_wdata_d      = mem_wdata_q;
    mem_wen_d        = mem_wen_q;
    mem_wstrb_d      = mem_wstrb_q;
    ifu_resp_valid_d = 1'b0;
    lsu_resp_valid_d = 1'b0;
    ifu_rdata_d      = ifu_rdata_q;
    lsu_rdata_d      = lsu_rdata_q;
    err_d            = err_q;

    case (state_q)
      IDLE: begin
        if (grant_lsu) begin
          owner_lsu_d     = 1'b1;
          mem_req_valid_d = 1'b1;
          mem_addr_d      = lsu_addr;
          mem_wdata_d     = lsu_wdata;
          mem_wen_d       = lsu_wen;
          mem_wstrb_d     = lsu_wstrb;
          state_d         = REQ;
          // Only contended grants count towards IFU starvation.
          if (ifu_req_valid) begin
            streak_d = streak_q + STREAK_W'(1);
          end
        end else if (grant_ifu) begin
          owner_lsu_d     = 1'b0;
          mem_req_valid_d = 1'b1;
          mem_addr_d      = ifu_addr;
          mem_wdata_d     = 32'h0;
          mem_wen_d       = 1'b0;
          mem_wstrb_d     = 4'b0000;
          streak_d        = '0;
          state_d         = REQ;
        end
      end

      REQ: begin
        if (mem_req_ready) begin
          mem_req_valid_d = 1'b0;
          cnt_d           = '0;
          state_d         = WAIT;
        end
      end

      WAIT: begin
        if (resp_fire) begin
          if (owner_lsu_q) begin
            lsu_resp_valid_d = 1'b1;
            lsu_rdata_d      = resp_data;
          end else begin
            ifu_resp_valid_d = 1'b1;
            ifu_rdata_d      = resp_data;
          end
          if (!mem_resp_valid) begin
            err_d = 1'b1;
          end
          state_d = RESP;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end

      RESP: begin
        state_d = IDLE;
      end

      default: begin
        state_d = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q          <= IDLE;
      streak_q         <= '0;
      cnt_q            <= '0;
      owner_lsu_q      <= 1'b0;
      mem_req_valid_q  <= 1'b0;
      mem_addr_q       <= 32'h0;
      mem_wdata_q      <= 32'h0;
      mem_wen_q        <= 1'b0;
      mem_wstrb_q      <= 4'b0000;
      ifu_resp_valid_q <= 1'b0;
      lsu_resp_valid_q <= 1'b0;
      ifu_rdata_q      <= 32'h0;
      lsu_rdata_q      <= 32'h0;
      err_q            <= 1'b0;
    end else begin
      state_q          <= state_d;
      streak_q         <= streak_d;
      cnt_q            <= cnt_d;
      owner_lsu_q      <= owner_lsu_d;
      mem_req_valid_q  <= mem_req_valid_d;
      mem_addr_q       <= mem_addr_d;
      mem_wdata_q      <= mem_wdata_d;
      mem_wen_q        <= mem_wen_d;
      mem_wstrb_q      <= mem_wstrb_d;
      ifu_resp_valid_q <= ifu_resp_valid_d;
      lsu_resp_valid_q <= lsu_resp_valid_d;
      ifu_rdata_q      <= ifu_rdata_d;
      lsu_rdata_q      <= lsu_rdata_d;
      err_q            <= err_d;
    end
  end

  // Readies are combinational but forced low while reset is asserted so that
  // every output reads zero during reset.
  assign ifu_req_ready  = rst && (state_q == IDLE) && grant_ifu;
  assign lsu_req_ready  = rst && (state_q == IDLE) && grant_lsu;

  assign ifu_resp_valid = ifu_resp_valid_q;
  assign ifu_rdata      = ifu_rdata_q;
  assign lsu_resp_valid = lsu_resp_valid_q;
  assign lsu_rdata      = lsu_rdata_q;
  assign mem_req_valid  = mem_req_valid_q;
  assign mem_addr       = mem_addr_q;
  assign mem_wdata      = mem_wdata_q;
  assign mem_wen        = mem_wen_q;
  assign mem_wstrb      = mem_wstrb_q;
  assign err            = err_q;

endmodule
`default_nettype wire

// File: doc/mem_arbiter.md
# mem_arbiter

Single-port memory arbiter sharing one downstream memory interface between the instruction fetch unit (IFU) and the load/store unit (LSU). It sits between the core and the unified memory model. It serialises requests with exactly one transaction outstanding, registers each response and returns it to the owning requester. It also applies LSU-priority arbitration with a starvation bound for IFU, plus a response watchdog.

## Interface
- TIMEOUT, 255: WAIT-state cycles without response before the watchdog fires; minimum 1.
- MAX_LSU_STREAK, 4: consecutive contended LSU grants allowed before IFU is forced; minimum 1.
- ERR_DATA, 32'hDEAD_BEEF: rdata returned on timeout.
- clk  in  1  single clock, rising edge.
- rst  in  1  asynchronous, active-low reset (asserted at 0).
- ifu_req_valid  in  1  IFU fetch request.
- ifu_req_ready  out  1  IFU request accepted this cycle.
- ifu_addr  in  32  fetch address.
- ifu_resp_valid  out  1  one-cycle response pulse to IFU.
- ifu_rdata  out  32  fetched word.
- lsu_req_valid  in  1  LSU request.
- lsu_req_ready  out  1  LSU request accepted this cycle.
- lsu_addr  in  32  data address.
- lsu_wen  in  1  1 = store, 0 = load.
- lsu_wdata  in  32  store data.
- lsu_wstrb  in  4  byte strobes.
- lsu_resp_valid  out  1  one-cycle response pulse to LSU; also acks stores.
- lsu_rdata  out  32  load data.
- mem_req_valid  out  1  downstream request.
- mem_req_ready  in  1  downstream accepts request.
- mem_addr / mem_wdata  out  32 each  latched request fields.
- mem_wen  out  1  latched write flag.
- mem_wstrb  out  4  latched strobes; 4'b0000 for IFU requests.
- mem_resp_valid  in  1  downstream response; one pulse per accepted request, loads and stores alike.
- mem_rdata  in  32  downstream read data.
- err  out  1  sticky timeout flag.

## Operation
- FSM states: IDLE, REQ, WAIT, RESP.
- IDLE:
  - Arbitrate among valid requesters.
  - Drive the winner's req_ready high combinationally. No ready is asserted without a matching valid.
  - On the edge, latch addr, wen, wdata and wstrb plus the owner bit, then go to REQ.
  - IFU requests latch wen=0 and wstrb=0.
- Arbitration:
  - Only one requester valid: it wins.
  - Both valid and streak < MAX_LSU_STREAK: LSU wins and streak increments.
  - Both valid and streak == MAX_LSU_STREAK: IFU wins.
  - Any IFU grant clears streak. An uncontended LSU grant leaves streak unchanged.
- REQ: mem_req_valid=1 with the latched fields held stable until mem_req_ready=1, then go to WAIT. Clear the watchdog counter on entry to WAIT.
- WAIT:
  - On mem_resp_valid: latch mem_rdata and go to RESP.
  - Otherwise increment the counter. When the counter reaches TIMEOUT, latch ERR_DATA, set err and go to RESP.
- RESP: assert the owner's resp_valid for exactly one cycle with its rdata valid, then go to IDLE. The non-owner's resp_valid stays 0.
- mem_resp_valid in IDLE, REQ or RESP is ignored: stray or late responses are dropped.
- ifu_rdata and lsu_rdata hold their last value outside response pulses.

## Timing
- Request-accept cycle T (IDLE): mem_req_valid at T+1.
- With ready at T+1 and response at T+2, resp_valid is at T+3. Minimum request-to-response latency is 3 cycles.
- Back-to-back: the next req_ready is earliest at T+4, the cycle after RESP. Throughput is at most 1 transaction per 4 cycles.
- Reset asserted in any state: state goes to IDLE and streak, counter and err to 0. All outputs are 0, including mem_req_valid, both resp_valids, both rdatas, the mem fields and err. Any in-flight downstream transaction is abandoned and its response is dropped.
- Timeout fires on the TIMEOUT-th consecutive WAIT cycle without response. A response arriving in that same cycle wins: real data is returned and err is not set.

## Test plan
- IFU-only fetch of 0x8000_0000, memory ready immediately with response 1 cycle later carrying 0x0000_0413 -> ifu_resp_valid pulses at T+3 with ifu_rdata=0x0000_0413; lsu_resp_valid stays 0.
- LSU store to 0x8010_0004, wdata 0x1234_5678, wstrb 4'b0011, mem_req_ready held low 3 cycles -> mem fields stable throughout REQ; lsu_resp_valid pulses once after mem_resp_valid.
- Both requesters valid continuously, MAX_LSU_STREAK=4 -> grant order LSU ×4, IFU, LSU ×4, IFU.
- No response, TIMEOUT=8 -> 8 WAIT cycles, then the owner receives 0xDEAD_BEEF and err=1 sticky until reset. A late mem_resp_valid is ignored.
- Reset asserted during WAIT, then released, then an IFU request -> all outputs 0 during reset. A stale mem_resp_valid after release is dropped; the new request completes normally.
